// File: rtl/riscv_csr_arbiter.sv
// Arbitrates the single CSR register-file port between the EX-stage core
// access and the debug unit. The core has priority. A wait counter bounds debug starvation.
module riscv_csr_arbiter #(
    parameter int unsigned MAX_WAIT  = 15,
    parameter int unsigned WAIT_BITS = $clog2(MAX_WAIT + 1)
) (
    input  logic        clk,
    input  logic        rst,

    input  logic        core_csr_access_i,
    input  logic [11:0] core_csr_addr_i,
    input  logic [31:0] core_csr_wdata_i,
    input  logic [1:0]  core_csr_op_i,
    output logic [31:0] core_csr_rdata_o,
    output logic        core_csr_stall_o,

    input  logic        dbg_halted_i,
    input  logic        dbg_req_i,
    input  logic        dbg_we_i,
    input  logic [11:0] dbg_addr_i,
    input  logic [31:0] dbg_wdata_i,
    output logic        dbg_gnt_o,
    output logic        dbg_rvalid_o,
    output logic [31:0] dbg_rdata_o,

    output logic        csr_access_o,
    output logic [11:0] csr_addr_o,
    output logic [31:0] csr_wdata_o,
    output logic [1:0]  csr_op_o,
    input  logic [31:0] csr_rdata_i
);

    typedef enum logic {
        IDLE = 1'b0,
        RESP = 1'b1
    } state_e;

    localparam logic [1:0]           OP_NONE  = 2'b00;
    localparam logic [1:0]           OP_WRITE = 2'b01;
    localparam logic [WAIT_BITS-1:0] WAIT_MAX = WAIT_BITS'(MAX_WAIT);

    state_e               fsm_q, fsm_d;
    logic [WAIT_BITS-1:0] wait_cnt_q, wait_cnt_d;
    logic [31:0]          dbg_rdata_q, dbg_rdata_d;
    logic                 dbg_win;

    assign dbg_win = (fsm_q == IDLE) & dbg_req_i &
                     (~core_csr_access_i | dbg_halted_i | (wait_cnt_q == WAIT_MAX));

    always_comb begin
        // NOTE: every signal gets a default before any branch so no latch is inferred.
        fsm_d            = fsm_q;
        wait_cnt_d       = wait_cnt_q;
        dbg_rdata_d      = dbg_rdata_q;
        csr_access_o     = core_csr_access_i;
        csr_addr_o       = core_csr_addr_i;
        csr_wdata_o      = core_csr_wdata_i;
        csr_op_o         = core_csr_access_i ? core_csr_op_i : OP_NONE;
        dbg_gnt_o        = 1'b0;
        core_csr_stall_o = 1'b0;

        case (fsm_q)
            IDLE: begin
                if (dbg_win) begin
                    csr_access_o     = 1'b1;
                    csr_addr_o       = dbg_addr_i;
                    csr_wdata_o      = dbg_wdata_i;
                    csr_op_o         = dbg_we_i ? OP_WRITE : OP_NONE;
                    dbg_gnt_o        = 1'b1;
                    core_csr_stall_o = core_csr_access_i;
                    // Captured before the write lands, so writes return the old value.
                    dbg_rdata_d      = csr_rdata_i;
                    wait_cnt_d       = '0;
                    fsm_d            = RESP;
                end else if (dbg_req_i) begin
                    if (wait_cnt_q != WAIT_MAX) begin
                        wait_cnt_d = wait_cnt_q + WAIT_BITS'(1);
                    end
                end else begin
                    wait_cnt_d = '0;
                end
            end
            RESP: begin
                fsm_d = IDLE;
            end
            default: begin
                fsm_d = IDLE;
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_q       <= IDLE;
            wait_cnt_q  <= '0;
            dbg_rdata_q <= '0;
        end else begin
            fsm_q       <= fsm_d;
            wait_cnt_q  <= wait_cnt_d;
            dbg_rdata_q <= dbg_rdata_d;
        end
    end

    assign dbg_rvalid_o     = (fsm_q == RESP);
    assign dbg_rdata_o      = dbg_rdata_q;
    assign core_csr_rdata_o = csr_rdata_i;

endmodule

// File: tb/tb_riscv_csr_arbiter.sv
// Directed self-checking bench for riscv_csr_arbiter: expected per-cycle
// outputs are queued with the stimulus and popped when the outputs are sampled.
module tb_riscv_csr_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        core_csr_access_i;
    logic [11:0] core_csr_addr_i;
    logic [31:0] core_csr_wdata_i;
    logic [1:0]  core_csr_op_i;
    logic [31:0] core_csr_rdata_o;
    logic        core_csr_stall_o;
    logic        dbg_halted_i;
    logic        dbg_req_i;
    logic        dbg_we_i;
    logic [11:0] dbg_addr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_gnt_o;
    logic        dbg_rvalid_o;
    logic [31:0] dbg_rdata_o;
    logic        csr_access_o;
    logic [11:0] csr_addr_o;
    logic [31:0] csr_wdata_o;
    logic [1:0]  csr_op_o;
    logic [31:0] csr_rdata_i;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic        gnt;
        logic        rvalid;
        logic [31:0] rdata;
        logic        stall;
        logic        access;
        logic [1:0]  op;
        logic [11:0] addr;
        logic [31:0] wdata;
    } exp_t;

    exp_t  sb_q[$];
    string tag_q[$];

    riscv_csr_arbiter #(.MAX_WAIT(15)) dut (
        .clk               (clk),
        .rst               (rst),
        .core_csr_access_i (core_csr_access_i),
        .core_csr_addr_i   (core_csr_addr_i),
        .core_csr_wdata_i  (core_csr_wdata_i),
        .core_csr_op_i     (core_csr_op_i),
        .core_csr_rdata_o  (core_csr_rdata_o),
        .core_csr_stall_o  (core_csr_stall_o),
        .dbg_halted_i      (dbg_halted_i),
        .dbg_req_i         (dbg_req_i),
        .dbg_we_i          (dbg_we_i),
        .dbg_addr_i        (dbg_addr_i),
        .dbg_wdata_i       (dbg_wdata_i),
        .dbg_gnt_o         (dbg_gnt_o),
        .dbg_rvalid_o      (dbg_rvalid_o),
        .dbg_rdata_o       (dbg_rdata_o),
        .csr_access_o      (csr_access_o),
        .csr_addr_o        (csr_addr_o),
        .csr_wdata_o       (csr_wdata_o),
        .csr_op_o          (csr_op_o),
        .csr_rdata_i       (csr_rdata_i)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic cmp(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic push(input string tag, input logic gnt, input logic rv, input logic [31:0] rdata,
                        input logic stall, input logic acc, input logic [1:0] op,
                        input logic [11:0] addr, input logic [31:0] wdata);
        exp_t e;
        e.gnt = gnt; e.rvalid = rv; e.rdata = rdata; e.stall = stall;
        e.access = acc; e.op = op; e.addr = addr; e.wdata = wdata;
        sb_q.push_back(e);
        tag_q.push_back(tag);
    endtask

    task automatic check_now();
        exp_t  e;
        string t;
        e = sb_q.pop_front();
        t = tag_q.pop_front();
        cmp({t, ".gnt"},    32'(dbg_gnt_o),        32'(e.gnt));
        cmp({t, ".rvalid"}, 32'(dbg_rvalid_o),     32'(e.rvalid));
        cmp({t, ".rdata"},  dbg_rdata_o,           e.rdata);
        cmp({t, ".stall"},  32'(core_csr_stall_o), 32'(e.stall));
        cmp({t, ".access"}, 32'(csr_access_o),     32'(e.access));
        cmp({t, ".op"},     32'(csr_op_o),         32'(e.op));
        cmp({t, ".addr"},   32'(csr_addr_o),       32'(e.addr));
        cmp({t, ".wdata"},  csr_wdata_o,           e.wdata);
        cmp({t, ".crdata"}, core_csr_rdata_o,      csr_rdata_i);
    endtask

    // Inputs are driven at posedge+1; outputs are checked at the following negedge.
    task automatic step(input string tag, input logic gnt, input logic rv, input logic [31:0] rdata,
                        input logic stall, input logic acc, input logic [1:0] op,
                        input logic [11:0] addr, input logic [31:0] wdata);
        push(tag, gnt, rv, rdata, stall, acc, op, addr, wdata);
        @(negedge clk);
        check_now();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic acc, input logic [11:0] addr, input logic [31:0] wdata,
                            input logic [1:0] op);
        core_csr_access_i = acc;
        core_csr_addr_i   = addr;
        core_csr_wdata_i  = wdata;
        core_csr_op_i     = op;
    endtask

    task automatic set_dbg(input logic req, input logic we, input logic [11:0] addr,
                           input logic [31:0] wdata);
        dbg_req_i   = req;
        dbg_we_i    = we;
        dbg_addr_i  = addr;
        dbg_wdata_i = wdata;
    endtask

    initial begin
        rst = 1'b1;
        set_core(1'b0, 12'h000, 32'h0, 2'b00);
        set_dbg(1'b0, 1'b0, 12'h000, 32'h0);
        dbg_halted_i = 1'b0;
        csr_rdata_i  = 32'h0;

        // Reset state
        #2;
        push("reset", 0, 0, 32'h0, 0, 0, 2'b00, 12'h000, 32'h0);
        check_now();
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
        step("idle", 0, 0, 32'h0, 0, 0, 2'b00, 12'h000, 32'h0);

        // Reset during RESP after a debug read of 0x341
        csr_rdata_i = 32'hDEAD_BEEF;
        set_dbg(1'b1, 1'b0, 12'h341, 32'h0);
        step("t1_gnt", 1, 0, 32'h0, 0, 1, 2'b00, 12'h341, 32'h0);
        set_dbg(1'b0, 1'b0, 12'h000, 32'h0);
        csr_rdata_i = 32'h0;
        push("t1_resp", 0, 1, 32'hDEAD_BEEF, 0, 0, 2'b00, 12'h000, 32'h0);
        check_now();
        rst = 1'b1;
        #2;
        push("t1_async_rst", 0, 0, 32'h0, 0, 0, 2'b00, 12'h000, 32'h0);
        check_now();
        rst = 1'b0;
        step("t1_after_rst", 0, 0, 32'h0, 0, 0, 2'b00, 12'h000, 32'h0);

        // Debug read of 0x300 with core idle
        csr_rdata_i = 32'h0000_0007;
        set_dbg(1'b1, 1'b0, 12'h300, 32'h0);
        step("t2_gnt", 1, 0, 32'h0, 0, 1, 2'b00, 12'h300, 32'h0);
        set_dbg(1'b0, 1'b0, 12'h000, 32'h0);
        step("t2_resp", 0, 1, 32'h7, 0, 0, 2'b00, 12'h000, 32'h0);

        // Starvation bound: core SET to 0x7A1 every cycle, debug writes 0x1 to 0x7A0
        csr_rdata_i = 32'h0000_0055;
        set_core(1'b1, 12'h7A1, 32'h10, 2'b10);
        set_dbg(1'b1, 1'b1, 12'h7A0, 32'h1);
        for (int i = 0; i < 15; i++) begin
            step("t3_core_wins", 0, 0, 32'h7, 0, 1, 2'b10, 12'h7A1, 32'h10);
        end
        step("t3_forced_gnt", 1, 0, 32'h7, 1, 1, 2'b01, 12'h7A0, 32'h1);
        set_dbg(1'b0, 1'b0, 12'h000, 32'h0);
        step("t3_resp", 0, 1, 32'h55, 0, 1, 2'b10, 12'h7A1, 32'h10);
        step("t3_hold", 0, 0, 32'h55, 0, 1, 2'b10, 12'h7A1, 32'h10);

        // Halted core: debug wins immediately over a simultaneous core write
        dbg_halted_i = 1'b1;
        csr_rdata_i  = 32'h0000_1234;
        set_core(1'b1, 12'h305, 32'hAA, 2'b01);
        set_dbg(1'b1, 1'b0, 12'h7B0, 32'h0);
        step("t4_gnt", 1, 0, 32'h55, 1, 1, 2'b00, 12'h7B0, 32'h0);
        set_dbg(1'b0, 1'b0, 12'h000, 32'h0);
        step("t4_resp", 0, 1, 32'h1234, 0, 1, 2'b01, 12'h305, 32'hAA);
        step("t4_after", 0, 0, 32'h1234, 0, 1, 2'b01, 12'h305, 32'hAA);
        dbg_halted_i = 1'b0;

        // Back-to-back debug reads with core idle
        set_core(1'b0, 12'h000, 32'h0, 2'b00);
        csr_rdata_i = 32'h11;
        set_dbg(1'b1, 1'b0, 12'h301, 32'h0);
        step("t5_gnt0", 1, 0, 32'h1234, 0, 1, 2'b00, 12'h301, 32'h0);
        csr_rdata_i = 32'h22;
        set_dbg(1'b1, 1'b0, 12'h302, 32'h0);
        step("t5_resp0", 0, 1, 32'h11, 0, 0, 2'b00, 12'h000, 32'h0);
        step("t5_gnt1", 1, 0, 32'h11, 0, 1, 2'b00, 12'h302, 32'h0);
        set_dbg(1'b0, 1'b0, 12'h000, 32'h0);
        step("t5_resp1", 0, 1, 32'h22, 0, 0, 2'b00, 12'h000, 32'h0);

        // Request dropped after 5 lost cycles, then re-raised: counter restarts
        csr_rdata_i = 32'h99;
        set_core(1'b1, 12'h7A2, 32'hF0, 2'b11);
        set_dbg(1'b1, 1'b0, 12'h7A3, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step("t6_lost", 0, 0, 32'h22, 0, 1, 2'b11, 12'h7A2, 32'hF0);
        end
        set_dbg(1'b0, 1'b0, 12'h7A3, 32'h0);
        step("t6_dropped", 0, 0, 32'h22, 0, 1, 2'b11, 12'h7A2, 32'hF0);
        set_dbg(1'b1, 1'b0, 12'h7A3, 32'h0);
        for (int i = 0; i < 15; i++) begin
            step("t6_reraised", 0, 0, 32'h22, 0, 1, 2'b11, 12'h7A2, 32'hF0);
        end
        step("t6_gnt", 1, 0, 32'h22, 1, 1, 2'b00, 12'h7A3, 32'h0);
        set_dbg(1'b0, 1'b0, 12'h000, 32'h0);
        step("t6_resp", 0, 1, 32'h99, 0, 1, 2'b11, 12'h7A2, 32'hF0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/riscv_csr_arbiter.md
Name: riscv_csr_arbiter

Overview:
- Shares the single CSR register-file port between the core pipeline (EX-stage CSR instructions) and the external debug unit.
- Sits between the EX stage / debug unit and the CSR block, and drives its csr_access/addr/wdata/op inputs.
- The core has priority. Debug wins immediately when the core is halted. A wait counter bounds debug starvation: when it expires, the core is stalled for one cycle.
- Debug accesses follow a req/gnt/rvalid handshake with a one-cycle registered response.

Parameters:
- MAX_WAIT, 15, cycles a pending debug request may lose arbitration before it is forced through (>=1).
- WAIT_BITS, $clog2(MAX_WAIT+1), width of the wait counter.

Ports:
- clk  in  1  clock, all logic on rising edge.
- rst  in  1  reset, asynchronous, active-high.
- core_csr_access_i  in  1  core requests a CSR access this cycle.
- core_csr_addr_i  in  12  core CSR address.
- core_csr_wdata_i  in  32  core write operand.
- core_csr_op_i  in  2  core op: NONE=00, WRITE=01, SET=10, CLEAR=11.
- core_csr_rdata_o  out  32  read data to core, equal to csr_rdata_i.
- core_csr_stall_o  out  1  core access not performed this cycle; core must hold its inputs.
- dbg_halted_i  in  1  core halted by debug; debug has absolute priority.
- dbg_req_i  in  1  debug access request, held until dbg_gnt_o.
- dbg_we_i  in  1  1 = write, 0 = read.
- dbg_addr_i  in  12  debug CSR address.
- dbg_wdata_i  in  32  debug write data.
- dbg_gnt_o  out  1  debug access performed this cycle.
- dbg_rvalid_o  out  1  dbg_rdata_o valid; one pulse, the cycle after the grant.
- dbg_rdata_o  out  32  registered CSR read data for the debug access.
- csr_access_o  out  1  to CSR block: access strobe.
- csr_addr_o  out  12  to CSR block: address.
- csr_wdata_o  out  32  to CSR block: write data.
- csr_op_o  out  2  to CSR block: op.
- csr_rdata_i  in  32  from CSR block: combinational read data.

Behaviour:
- FSM states: IDLE, RESP. Registered state: fsm, wait_cnt, dbg_rdata_q, which drives dbg_rdata_o.
- Reset values: fsm=IDLE, wait_cnt=0, dbg_rvalid_o=0, dbg_rdata_o=0. All combinational outputs with idle inputs are 0 (csr_access_o=0, csr_op_o=NONE, dbg_gnt_o=0, core_csr_stall_o=0).
- dbg_win = (fsm==IDLE) & dbg_req_i & (~core_csr_access_i | dbg_halted_i | wait_cnt==MAX_WAIT).
- When dbg_win is set, in the same cycle:
  - csr_access_o=1, csr_addr_o=dbg_addr_i, csr_wdata_o=dbg_wdata_i, csr_op_o = dbg_we_i ? WRITE : NONE.
  - dbg_gnt_o=1.
  - core_csr_stall_o=core_csr_access_i.
  - dbg_rdata_q <= csr_rdata_i, which is the pre-write value for writes.
  - fsm <= RESP, wait_cnt <= 0.
- Otherwise the CSR port passes the core through: csr_access_o=core_csr_access_i, and addr/wdata/op are the core's. When core_csr_access_i=0, op is forced to NONE.
- RESP state lasts exactly 1 cycle:
  - dbg_rvalid_o=1; fsm <= IDLE.
  - No grant is possible in RESP, so debug throughput is at most 1 access per 2 cycles.
  - The core is never stalled in RESP.
- wait_cnt behaviour:
  - In IDLE with dbg_req_i=1 and no dbg_win: increment, saturating at MAX_WAIT.
  - On dbg_req_i=0: cleared.
  - In RESP: held.
- Starvation bound: a continuously requested debug access is granted no later than MAX_WAIT+1 IDLE cycles after its request is raised.
- Simultaneous core and debug requests: the core wins unless dbg_halted_i=1 or wait_cnt==MAX_WAIT.
- Core stall is asserted only on a debug-win cycle. The core's retry in the next cycle (RESP) always succeeds.
- dbg_rdata_o holds its value until the next grant.
- Reset mid-operation (e.g. in RESP): returns to IDLE, the response pulse is dropped, dbg_rdata_o=0 and the counter clears. The debug unit must reissue.
- No X propagation: every output has a defined value every cycle.

Test Plan:
1. Reset asserted during RESP after a debug read of 0x341 -> dbg_rvalid_o falls to 0 asynchronously and dbg_rdata_o=0; after release, all outputs idle.
2. Core idle; debug read of 0x300 with CSR returning 0x00000007 -> dbg_gnt_o=1 in cycle 0 with csr_op_o=00; dbg_rvalid_o=1 and dbg_rdata_o=0x7 in cycle 1; no core stall.
3. Core issues continuous SET to 0x7A1; debug requests write 0x1 to 0x7A0 with MAX_WAIT=15:
   - cycles 0-14: core passes through, no grant.
   - cycle 15: dbg_gnt_o=1, csr_op_o=01, core_csr_stall_o=1.
   - cycle 16: core passes through, dbg_rvalid_o=1.
4. dbg_halted_i=1 with simultaneous core and debug requests -> debug granted in cycle 0, core stalled exactly 1 cycle.
5. Two debug requests back-to-back with the core idle -> grants in cycles 0 and 2, rvalid pulses in cycles 1 and 3; dbg_gnt_o=0 in cycle 1.
6. Debug request dropped after 5 lost cycles, then re-raised with the core still busy -> wait_cnt restarts from 0, and the grant occurs 16 cycles after the re-raise.
